// File: rtl/mwadd_seq.sv
// ---------------------------------------------------------------------------
// mwadd_seq -- multi-word sequential adder.
//
// Adds two W-bit operands (W = N*WORDS) plus a carry-in using a single N-bit
// ripple-carry slice. The slice is reused once per chunk, lowest chunk first.
// An operand pair is accepted in IDLE. The result is presented WORDS cycles
// later and held in DONE until the consumer takes it.
//
// Parameters:
//   N      chunk width in bits (width of the ripple-carry slice)
//   WORDS  number of chunks per operand (>= 1)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair and carry-in present
//   in_ready   high only in IDLE; accept = in_valid & in_ready
//   A, B       W-bit operands
//   Cin        carry into chunk 0
//   out_valid  result present on S/Cout (state DONE)
//   out_ready  consumer takes the result
//   S          sum A+B+Cin modulo 2^W (holds last result in IDLE)
//   Cout       carry out of bit W-1
//   OVF        signed overflow of the W-bit add; present only when the
//              macro MWADD_SEQ_OVF_EN is defined
//   busy       high in RUN or DONE
// ---------------------------------------------------------------------------
module mwadd_seq #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   A,
  input  logic [N*WORDS-1:0]   B,
  input  logic                 Cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   S,
  output logic                 Cout,
`ifdef MWADD_SEQ_OVF_EN
  output logic                 OVF,
`endif
  output logic                 busy
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_nxt;

  logic [W-1:0]    a_p0;
  logic [W-1:0]    b_p0;
  logic            carry_p0;
  logic [IW-1:0]   idx;
  logic [W-1:0]    s_p1;
  logic            cout_p1;
`ifdef MWADD_SEQ_OVF_EN
  logic            ovf_p1;
`endif

  logic [N:0]      slice;
  logic            last;

  // N-bit ripple-carry slice; returns {carry_out, sum}.
  function automatic logic [N:0] rca_slice(input logic [N-1:0] a,
                                           input logic [N-1:0] b,
                                           input logic         ci);
    logic         c;
    logic [N-1:0] s;
    c = ci;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

  assign slice = rca_slice(a_p0[idx*N +: N], b_p0[idx*N +: N], carry_p0);
  assign last  = (idx == IW'(WORDS - 1));

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // ---- state-decoded outputs ----
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  // ---- p0: operand capture / p1: chunk-serial accumulation ----
  always_ff @(posedge clk) begin
    if (rst) begin
      a_p0     <= '0;
      b_p0     <= '0;
      carry_p0 <= 1'b0;
      idx      <= '0;
      s_p1     <= '0;
      cout_p1  <= 1'b0;
`ifdef MWADD_SEQ_OVF_EN
      ovf_p1   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_p0     <= A;
            b_p0     <= B;
            carry_p0 <= Cin;
            idx      <= '0;
          end
        end
        RUN: begin
          s_p1[idx*N +: N] <= slice[N-1:0];
          carry_p0         <= slice[N];
          if (last) begin
            cout_p1 <= slice[N];
`ifdef MWADD_SEQ_OVF_EN
            // Carry into bit W-1 equals a ^ b ^ sum at that bit.
            ovf_p1  <= a_p0[W-1] ^ b_p0[W-1] ^ slice[N-1] ^ slice[N];
`endif
            idx     <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign S    = s_p1;
  assign Cout = cout_p1;
`ifdef MWADD_SEQ_OVF_EN
  assign OVF  = ovf_p1;
`endif

endmodule

// File: tb/tb_mwadd_seq.sv
`timescale 1ns/1ps
module tb_mwadd_seq;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;
  localparam int II    = WORDS + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         Cout;
  logic         busy;
`ifdef MWADD_SEQ_OVF_EN
  logic         OVF;
`endif

  mwadd_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
`ifdef MWADD_SEQ_OVF_EN
    .OVF       (OVF),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   acc_log[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic held   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: plain (W+1)-bit arithmetic on the whole operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input int acc);
    exp_t       e;
    logic [W:0] full;
    full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e.s   = full[W-1:0];
    e.c   = full[W];
    e.v   = (a[W-1] == b[W-1]) && (e.s[W-1] != a[W-1]);
    e.acc = acc;
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corner [4];
    corner[0] = {W{1'b1}};
    corner[1] = '0;
    corner[2] = {1'b1, {(W-1){1'b0}}};
    corner[3] = {1'b0, {(W-1){1'b1}}};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  // Scoreboard: push on accept, compare whenever a result is presented.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(A, B, Cin, cyc + 1));
        acc_log.push_back(cyc + 1);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          check("sum", {16'b0, S}, {16'b0, exp_q[0].s});
          check("cout", {31'b0, Cout}, {31'b0, exp_q[0].c});
`ifdef MWADD_SEQ_OVF_EN
          check("ovf", {31'b0, OVF}, {31'b0, exp_q[0].v});
`endif
          if (!held) check("latency", cyc - exp_q[0].acc, WORDS);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      held = out_valid && !out_ready;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    int t;
    @(posedge clk); #1;
    A = a; B = b; Cin = ci; in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 50);
    if (!in_ready) check("accept_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input int budget);
    int t;
    @(posedge clk); #1;
    out_ready = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] pa [3];
    logic [W-1:0] pb [3];
    int           t;
    int           sent;
    logic         will_acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_s", {16'b0, S}, 32'd0);
    check("rst_cout", {31'b0, Cout}, 32'd0);
`ifdef MWADD_SEQ_OVF_EN
    check("rst_ovf", {31'b0, OVF}, 32'd0);
`endif

    // Full carry ripple through every chunk.
    out_ready = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0);
    @(negedge clk);
    check("run_busy", {31'b0, busy}, 32'd1);
    check("run_in_ready", {31'b0, in_ready}, 32'd0);
    drain(30);

    // Result held while consumer stalls.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(16'h1234, 16'h4321, 1'b1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!out_valid && t < 20);
    check("stall_valid_seen", {31'b0, out_valid}, 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_idle_in_ready", {31'b0, in_ready}, 32'd1);
    check("stall_idle_out_valid", {31'b0, out_valid}, 32'd0);
    check("stall_idle_s_held", {16'b0, S}, 32'h5556);
    check("stall_idle_cout_held", {31'b0, Cout}, 32'd0);

    // Abort in the second RUN cycle.
    send(16'hAAAA, 16'h5555, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("abort_s", {16'b0, S}, 32'd0);
    check("abort_cout", {31'b0, Cout}, 32'd0);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    repeat (10) @(negedge clk);

    // Signed-overflow corners.
    send(16'h7FFF, 16'h0001, 1'b0);
    drain(30);
    send(16'hFFFF, 16'h0001, 1'b0);
    drain(30);
    send(16'h8000, 16'h8000, 1'b0);
    drain(30);

    // Back-to-back with in_valid held high.
    pa[0] = 16'h0F0F; pb[0] = 16'hF0F1;
    pa[1] = 16'h9999; pb[1] = 16'h6667;
    pa[2] = 16'hC3A5; pb[2] = 16'h1234;
    acc_log.delete();
    @(posedge clk); #1;
    out_ready = 1'b1;
    A = pa[0]; B = pb[0]; Cin = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!in_ready && t < 30);
      @(posedge clk); #1;
      if (k < 2) begin
        A = pa[k+1]; B = pb[k+1]; Cin = 1'(k);
      end else begin
        in_valid = 1'b0; A = W'($urandom); B = W'($urandom);
      end
    end
    drain(40);
    check("b2b_accepts", acc_log.size(), 32'd3);
    if (acc_log.size() == 3) begin
      check("b2b_spacing_0", acc_log[1] - acc_log[0], II);
      check("b2b_spacing_1", acc_log[2] - acc_log[1], II);
    end

    // Randomized traffic with random consumer back-pressure.
    sent = 0;
    in_valid = 1'b0;
    for (int c = 0; c < 3000 && (sent < 40 || in_valid); c++) begin
      @(negedge clk);
      will_acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (will_acc) begin
        in_valid = 1'b0;
        sent++;
        A = W'($urandom); B = W'($urandom);
      end
      if (!in_valid && sent < 40 && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b1;
        A = pick(); B = pick(); Cin = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    check("rand_sent", sent, 32'd40);
    drain(200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
